// File: rtl/wb_writer_if.sv
// MEM-to-writeback handshake, data-memory read response and register-file
// write port of wb_writer, bundled with driver (master) and block (slave) views.
interface wb_writer_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              mem_valid_i;
  logic              mem_ready_o;
  logic              mem_wreg_i;
  logic [REG_AW-1:0] mem_waddr_i;
  logic [XLEN-1:0]   mem_wdata_i;
  logic              mem_is_load_i;
  logic [2:0]        mem_ld_type_i;
  logic [1:0]        mem_addr_lo_i;
  logic              dmem_rvalid_i;
  logic [XLEN-1:0]   dmem_rdata_i;
  logic              we_o;
  logic [REG_AW-1:0] waddr_o;
  logic [XLEN-1:0]   wdata_o;
  logic              err_o;
  logic [31:0]       retire_cnt_o;

  modport master (
    output mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i, mem_is_load_i,
           mem_ld_type_i, mem_addr_lo_i, dmem_rvalid_i, dmem_rdata_i,
    input  mem_ready_o, we_o, waddr_o, wdata_o, err_o, retire_cnt_o
  );

  modport slave (
    input  mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i, mem_is_load_i,
           mem_ld_type_i, mem_addr_lo_i, dmem_rvalid_i, dmem_rdata_i,
    output mem_ready_o, we_o, waddr_o, wdata_o, err_o, retire_cnt_o
  );
endinterface

// File: rtl/wb_writer.sv
// Writeback stage: retires ALU results directly and loads after the data-memory
// response, aligning/extending load data and flagging illegal or misaligned loads.
module wb_writer #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  state_t            state, state_n;
  logic              accept;

  // Instruction fields held while a load waits for its response
  logic              wreg_q;
  logic [REG_AW-1:0] waddr_q;
  logic [2:0]        ld_type_q;
  logic [1:0]        addr_lo_q;

  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   aligned;
  logic              ld_err;

  logic              we_n, err_n;
  logic [REG_AW-1:0] waddr_n;
  logic [XLEN-1:0]   wdata_n;

  logic              we_q, err_q;
  logic [REG_AW-1:0] waddr_r;
  logic [XLEN-1:0]   wdata_r;
  logic [31:0]       cnt_q;

  assign bus.mem_ready_o = !rst_i && ((state == IDLE) || (state == WRITE));
  assign accept          = bus.mem_valid_i && bus.mem_ready_o;

  always_comb begin
    shifted = bus.dmem_rdata_i >> {addr_lo_q, 3'b000};
    case (ld_type_q)
      LD_LB:   aligned = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LD_LH:   aligned = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LD_LBU:  aligned = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LD_LHU:  aligned = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
    ld_err = (ld_type_q == 3'd3) || (ld_type_q == 3'd6) || (ld_type_q == 3'd7) ||
             (((ld_type_q == LD_LH) || (ld_type_q == LD_LHU)) && addr_lo_q[0]) ||
             ((ld_type_q == LD_LW) && (addr_lo_q != 2'b00));
  end

  // Next-state logic also computes the registered writeback outputs, so the
  // write port is stable for the whole WRITE cycle and holds afterwards.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n = state;
    we_n    = 1'b0;
    err_n   = 1'b0;
    waddr_n = waddr_r;
    wdata_n = wdata_r;
    case (state)
      IDLE, WRITE: begin
        if (accept) begin
          if (bus.mem_is_load_i) begin
            state_n = WAIT_LOAD;
          end else begin
            state_n = WRITE;
            we_n    = bus.mem_wreg_i && (bus.mem_waddr_i != '0);
            waddr_n = bus.mem_waddr_i;
            wdata_n = bus.mem_wdata_i;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (bus.dmem_rvalid_i) begin
          state_n = WRITE;
          err_n   = ld_err;
          we_n    = !ld_err && wreg_q && (waddr_q != '0);
          waddr_n = waddr_q;
          wdata_n = aligned;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wreg_q    <= 1'b0;
      waddr_q   <= '0;
      ld_type_q <= 3'd0;
      addr_lo_q <= 2'b00;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      waddr_r   <= '0;
      wdata_r   <= '0;
      cnt_q     <= 32'd0;
    end else begin
      state   <= state_n;
      we_q    <= we_n;
      err_q   <= err_n;
      waddr_r <= waddr_n;
      wdata_r <= wdata_n;
      if (accept) begin
        wreg_q    <= bus.mem_wreg_i;
        waddr_q   <= bus.mem_waddr_i;
        ld_type_q <= bus.mem_ld_type_i;
        addr_lo_q <= bus.mem_addr_lo_i;
      end
      if (state == WRITE) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.we_o         = we_q;
  assign bus.err_o        = err_q;
  assign bus.waddr_o      = waddr_r;
  assign bus.wdata_o      = wdata_r;
  assign bus.retire_cnt_o = cnt_q;

endmodule
